// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port. x0 writes are sunk,
// and the winning real write is registered onto rd_* one cycle after acceptance.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*5-1:0]    req_addr_i,
  input  logic [NUM_REQ*32-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic                    stall_i,
  output logic [4:0]              rd_addr_o,
  output logic [31:0]             rd_data_o,
  output logic                    rd_wren_o,
  output logic [CNT_W-1:0]        conflict_cnt_o,
  output logic [2:0]              grant_idx_o
);

  logic [NUM_REQ-1:0] real_req, x0_req, gnt_oh;
  logic [7:0]         real_pad;
  logic [3:0]         num_real;
  logic               gnt_found;
  logic [2:0]         gnt_idx, cand;
  logic [4:0]         gnt_addr;
  logic [31:0]        gnt_data;

  logic [4:0]         rd_addr_q;
  logic [31:0]        rd_data_q;
  logic               rd_wren_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         grant_idx_q;

  // Classify requests into real writes and x0 writes.
  always_comb begin
    real_req = '0;
    x0_req   = '0;
    num_real = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k]) begin
        if (req_addr_i[5*k +: 5] == 5'd0) x0_req[k] = 1'b1;
        else                               real_req[k] = 1'b1;
      end
      num_real = num_real + 4'(real_req[k]);
    end
  end

  // Search starts just after the last granted index and wraps around.
  always_comb begin
    real_pad  = 8'(real_req);
    gnt_found = 1'b0;
    gnt_idx   = grant_idx_q;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 3'((32'(grant_idx_q) + i) % NUM_REQ);
      if (!gnt_found && real_pad[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_found = gnt_found & ~stall_i & ~rst_i;
  end

  always_comb begin
    gnt_oh   = '0;
    gnt_addr = '0;
    gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt_oh[k] = gnt_found && (gnt_idx == 3'(k));
      if (gnt_oh[k]) begin
        gnt_addr = req_addr_i[5*k +: 5];
        gnt_data = req_data_i[32*k +: 32];
      end
    end
    req_ready_o = rst_i ? '0 : (x0_req | gnt_oh);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_wren_q   <= 1'b0;
      cnt_q       <= '0;
      grant_idx_q <= 3'(NUM_REQ - 1);
    end else begin
      rd_wren_q <= gnt_found;
      if (gnt_found) begin
        rd_addr_q   <= gnt_addr;
        rd_data_q   <= gnt_data;
        grant_idx_q <= gnt_idx;
      end
      if (num_real >= 4'd2 && !stall_i && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rd_addr_o      = rd_addr_q;
  assign rd_data_o      = rd_data_q;
  assign rd_wren_o      = rd_wren_q;
  assign conflict_cnt_o = cnt_q;
  assign grant_idx_o    = grant_idx_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference model predicts ready and
// the next registered write each cycle; predictions are queued and checked after the edge.
module tb_regfile_wb_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   valid;
  logic [NR*5-1:0] addr;
  logic [NR*32-1:0] data;
  logic [NR-1:0]   ready;
  logic            stall;
  logic [4:0]      rd_addr;
  logic [31:0]     rd_data;
  logic            rd_wren;
  logic [CW-1:0]   cnt;
  logic [2:0]      gidx;

  regfile_wb_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (valid),
    .req_addr_i     (addr),
    .req_data_i     (data),
    .req_ready_o    (ready),
    .stall_i        (stall),
    .rd_addr_o      (rd_addr),
    .rd_data_o      (rd_data),
    .rd_wren_o      (rd_wren),
    .conflict_cnt_o (cnt),
    .grant_idx_o    (gidx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  idx;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          m_ptr   = NR - 1;
  logic [4:0]  m_addr  = '0;
  logic [31:0] m_data  = '0;
  logic [3:0]  m_cnt   = '0;
  logic [31:0] rf [32];
  int          wr0_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: predict at the falling edge, compare after the rising edge.
  task automatic step();
    logic [NR-1:0] exp_rdy;
    int            g;
    int            nreal;
    exp_t          e;
    @(negedge clk);
    exp_rdy = '0;
    g       = -1;
    nreal   = 0;
    for (int k = 0; k < NR; k++)
      if (valid[k] && addr[5*k +: 5] != 5'd0) nreal++;
    if (!rst) begin
      for (int k = 0; k < NR; k++)
        if (valid[k] && addr[5*k +: 5] == 5'd0) exp_rdy[k] = 1'b1;
      if (!stall) begin
        for (int i = 1; i <= NR; i++) begin
          int k;
          k = (m_ptr + i) % NR;
          if (g < 0 && valid[k] && addr[5*k +: 5] != 5'd0) g = k;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check_eq("ready", 32'(ready), 32'(exp_rdy));
    if (rst) begin
      m_addr = '0; m_data = '0; m_ptr = NR - 1; m_cnt = '0;
      e.wren = 1'b0;
    end else begin
      e.wren = (g >= 0);
      if (g >= 0) begin
        m_addr = addr[5*g +: 5];
        m_data = data[32*g +: 32];
        m_ptr  = g;
      end
      if (nreal >= 2 && !stall && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end
    e.addr = m_addr; e.data = m_data; e.idx = 3'(m_ptr); e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("wren", 32'(rd_wren), 32'(e.wren));
    check_eq("addr", 32'(rd_addr), 32'(e.addr));
    check_eq("data", rd_data, e.data);
    check_eq("gidx", 32'(gidx), 32'(e.idx));
    check_eq("cnt", 32'(cnt), 32'(e.cnt));
    if (rd_wren) begin
      rf[rd_addr] = rd_data;
      if (rd_addr == 5'd0) wr0_seen++;
    end
  endtask

  task automatic idle_in();
    valid = '0; addr = '0; data = '0; stall = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
    valid[k]       = 1'b1;
    addr[5*k +: 5] = a;
    data[32*k +: 32] = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    idle_in();
    @(posedge clk);
    #1;

    // Single requester
    do_reset();
    set_req(1, 5'd5, 32'hDEADBEEF);
    step();
    valid = '0;
    step();
    step();

    // Round-robin fairness with all requesters busy
    do_reset();
    for (int k = 0; k < NR; k++) set_req(k, 5'(k + 1), 32'h100 + 32'(k));
    repeat (6) step();
    idle_in();
    step();

    // x0 sink alongside a real write
    do_reset();
    set_req(0, 5'd0, 32'hBAD0);
    set_req(2, 5'd7, 32'h7777);
    step();
    idle_in();
    step();

    // Stall holds off a real request
    do_reset();
    set_req(1, 5'd9, 32'h9999);
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    step();
    valid = '0;
    step();

    // Same-address writes land in grant order
    do_reset();
    rf[4] = '0;
    set_req(0, 5'd4, 32'h11);
    set_req(1, 5'd4, 32'h22);
    step();
    valid[0] = 1'b0;
    step();
    idle_in();
    step();
    check_eq("rf4_final", rf[4], 32'h22);

    // Counter saturation, then reset mid-stream
    do_reset();
    set_req(0, 5'd3, 32'hA);
    set_req(2, 5'd6, 32'hB);
    repeat (20) step();
    check_eq("cnt_sat", 32'(cnt), 32'd15);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Random traffic including x0, stall and occasional reset
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < NR; k++) begin
        valid[k]         = 1'($urandom_range(0, 1));
        addr[5*k +: 5]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        data[32*k +: 32] = $urandom;
      end
      stall = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 29) == 0);
      step();
    end
    idle_in();
    step();

    check_eq("no_x0_write", 32'(wr0_seen), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the register file's single write port among NUM_REQ writeback requesters, e.g. ALU, load unit and CSR unit.
- Uses a round-robin grant with a valid/ready handshake per requester.
- Drives the register file write port (rd_addr, rd_data, rd_wren) from registered outputs, one cycle after acceptance.
- Sinks x0 writes, supports a global stall, and keeps a saturating contention counter for performance analysis.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- CNT_W, 16, width of the contention counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester write request valid.
- req_addr_i  input  NUM_REQ*5  per-requester destination register; requester k occupies bits [5k+4:5k].
- req_data_i  input  NUM_REQ*32  per-requester write data; requester k occupies bits [32k+31:32k].
- req_ready_o  output  NUM_REQ  per-requester accept; a transfer happens when valid and ready are both 1.
- stall_i  input  1  blocks all non-x0 grants while high.
- rd_addr_o  output  5  write address to the register file.
- rd_data_o  output  32  write data to the register file.
- rd_wren_o  output  1  write enable to the register file.
- conflict_cnt_o  output  CNT_W  saturating count of contention cycles.
- grant_idx_o  output  3  index of the requester most recently granted a non-x0 write.

Behaviour:
- Reset (rst_i=1 at an edge):
  - rd_wren_o=0, rd_addr_o=0, rd_data_o=0, conflict_cnt_o=0, grant_idx_o=NUM_REQ-1.
  - The round-robin pointer is set to NUM_REQ-1, so requester 0 has top priority after reset.
  - While rst_i=1, req_ready_o=0 for every requester.
- Request classes:
  - A request is "real" when req_valid_i[k]=1 and req_addr≠0.
  - A request is "x0" when req_valid_i[k]=1 and req_addr=0.
- x0 sink:
  - Every x0 request gets req_ready_o[k]=1 in the same cycle, regardless of stall_i or arbitration.
  - An x0 request never generates rd_wren_o and never moves the pointer.
- Arbitration (combinational, each cycle, stall_i=0):
  - Among real requests, grant the first one found searching from (grant_idx_o+1) mod NUM_REQ upward with wrap-around.
  - At most one real request gets ready=1 per cycle.
  - req_ready_o depends combinationally on req_valid_i. A requester must not make valid depend on ready.
- Grant registration (next edge):
  - On a real grant: rd_addr_o and rd_data_o take the granted request, rd_wren_o=1, grant_idx_o=granted index.
  - With no real grant: rd_wren_o=0; rd_addr_o, rd_data_o and grant_idx_o hold their values.
  - Latency from acceptance to the register file write edge is exactly one cycle. Sustained throughput is one write per cycle.
- Stall:
  - stall_i=1 forces ready=0 for all real requests; x0 requests are still sunk.
  - The next rd_wren_o is 0 and the pointer holds.
  - A write already registered in rd_* completes normally; there is one write in flight at most.
- Same-address conflicts:
  - Real requests to the same rd are serviced in grant order.
  - The later grant overwrites the earlier one, so the register file holds the value of the last granted write.
  - The arbiter does not merge or reorder writes.
- Contention counter:
  - Increments by 1 at each edge where two or more real requests are valid and stall_i=0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - It is cleared only by reset.
- Requester obligations: a requester holds valid, addr and data stable until accepted. The arbiter does not check this.
- Reset mid-operation: a request pending in the same cycle as rst_i is not accepted and is not written. The requester must re-present it after reset.

Test Plan:
- Single requester: rst_i high for 2 cycles, then req1 valid with addr=5, data=0xDEADBEEF. Expect ready1=1 in the same cycle; one cycle later rd_wren_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF, grant_idx_o=1; the cycle after, rd_wren_o=0.
- Round-robin fairness: after reset, all 3 requesters continuously valid with addrs 1, 2, 3. Expect grants in order 0,1,2,0,1,2, i.e. rd_addr_o sequence 1,2,3,1,2,3 on consecutive cycles. conflict_cnt_o increments every cycle.
- x0 sink: req0 at addr=0 and req2 at addr=7 valid together. Expect ready0=1 and ready2=1 in the same cycle. Next cycle rd_wren_o=1 with rd_addr_o=7; no write to address 0 ever occurs. conflict_cnt_o does not increment.
- Stall: req1 valid at addr=9 with stall_i=1 for 3 cycles. Expect ready1=0 and rd_wren_o=0 throughout. When stall_i falls, ready1=1 and the write appears one cycle later.
- Same-address conflict: req0 (addr=4, data=0x11) and req1 (addr=4, data=0x22) valid from reset. Expect a write of 0x11 followed by a write of 0x22 on consecutive cycles; the final register file value is 0x22.
- Counter saturation and reset: set CNT_W=4 and hold 2 real requests valid for 20 cycles. Expect conflict_cnt_o to stop at 15. Asserting rst_i mid-stream clears the counter, drops rd_wren_o to 0, and accepts no request during the reset cycle.
